// File: rtl/stream_muxn.sv
// N-channel registered stream multiplexer with valid/ready handshake.
// Arbitration is fixed-priority (MODE 0) or round-robin (MODE 1), one beat per cycle.
module stream_muxn #(
  parameter int XLEN = 32,
  parameter int N    = 4,
  parameter int MODE = 0,
  parameter int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N-1:0]      in_valid,
  input  logic [N*XLEN-1:0] in_data,
  output logic [N-1:0]      in_ready,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  // Search order starts at 'start' and wraps at N-1, so index values >= N
  // are never produced even when N is not a power of two. The loop runs
  // downwards so that the closest requester to 'start' is written last and wins.
  // Result: {found, index}.
  function automatic logic [SELW:0] pick(input logic [N-1:0]    valid,
                                         input logic [SELW-1:0] start);
    logic [SELW:0] res;
    int            idx;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx -= N;
      if (valid[idx]) res = {1'b1, SELW'(idx)};
    end
    return res;
  endfunction

  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     out_data_q,  out_data_d;
  logic [SELW-1:0]     out_sel_q,   out_sel_d;
  logic [SELW-1:0]     rr_ptr_q,    rr_ptr_d;

  logic                load;
  logic [SELW:0]       pick_res;
  logic                grant_any;
  logic [SELW-1:0]     grant_idx;
  logic [N-1:0]        grant;
  logic                transfer;

  // NOTE: every signal driven here gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    load      = !out_valid_q || out_ready;
    pick_res  = pick(in_valid, (MODE == 1) ? rr_ptr_q : '0);
    grant_any = pick_res[SELW];
    grant_idx = pick_res[SELW-1:0];
    grant     = '0;
    if (grant_any) grant[grant_idx] = 1'b1;

    // Ready is forced low while reset is asserted so no source sees a
    // handshake on an edge whose capture reset will discard anyway.
    in_ready  = (reset_n && load) ? grant : '0;
    transfer  = reset_n && load && grant_any;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;

    if (load) begin
      out_valid_d = grant_any;
      if (transfer) begin
        out_data_d = in_data[int'(grant_idx)*XLEN +: XLEN];
        out_sel_d  = grant_idx;
        if (MODE == 1) begin
          rr_ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order. The data register is reset
  // too, because the consumer-visible out_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_muxn.sv
// Self-checking bench: fixed-priority N=4, round-robin N=4 and round-robin N=3
// instances share stimulus and are compared against a per-instance reference model.
module tb_stream_muxn;
  localparam int XLEN = 32;
  localparam int N    = 4;
  localparam int NU   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N*XLEN-1:0] in_data;
  logic              out_ready;

  logic [N-1:0]      rdy [NU];
  logic              ov  [NU];
  logic [XLEN-1:0]   od  [NU];
  logic [1:0]        os  [NU];
  logic [2:0]        rdy_n3;

  assign rdy[2] = {1'b0, rdy_n3};

  stream_muxn #(.XLEN(XLEN), .N(4), .MODE(0)) u_fp (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_sel(os[0]),
    .out_ready(out_ready));

  stream_muxn #(.XLEN(XLEN), .N(4), .MODE(1)) u_rr (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_sel(os[1]),
    .out_ready(out_ready));

  stream_muxn #(.XLEN(XLEN), .N(3), .MODE(1)) u_rr3 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2:0]),
    .in_data(in_data[3*XLEN-1:0]), .in_ready(rdy_n3), .out_valid(ov[2]),
    .out_data(od[2]), .out_sel(os[2]), .out_ready(out_ready));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per instance, the output register contents and the
  // round-robin start point, advanced with plain index arithmetic.
  int              m_mode [NU] = '{0, 1, 1};
  int              m_n    [NU] = '{4, 4, 3};
  bit              m_ov   [NU];
  logic [XLEN-1:0] m_od   [NU];
  int              m_os   [NU];
  int              m_rr   [NU];

  function automatic int model_grant(input int u);
    int start;
    start = (m_mode[u] == 1) ? m_rr[u] : 0;
    for (int k = 0; k < m_n[u]; k++) begin
      if (in_valid[(start + k) % m_n[u]]) return (start + k) % m_n[u];
    end
    return -1;
  endfunction

  task automatic check_ready();
    for (int u = 0; u < NU; u++) begin
      int g;
      logic [N-1:0] exp;
      g   = model_grant(u);
      exp = '0;
      if (reset_n && (!m_ov[u] || out_ready) && g >= 0) exp[g] = 1'b1;
      check($sformatf("in_ready[u%0d]", u), 64'(rdy[u]), 64'(exp));
    end
  endtask

  task automatic model_edge();
    int g [NU];
    for (int u = 0; u < NU; u++) g[u] = model_grant(u);
    for (int u = 0; u < NU; u++) begin
      if (!reset_n) begin
        m_ov[u] = 0; m_od[u] = '0; m_os[u] = 0; m_rr[u] = 0;
      end else if (!m_ov[u] || out_ready) begin
        if (g[u] >= 0) begin
          m_ov[u] = 1;
          m_od[u] = in_data[g[u]*XLEN +: XLEN];
          m_os[u] = g[u];
          if (m_mode[u] == 1) m_rr[u] = (g[u] + 1) % m_n[u];
        end else begin
          m_ov[u] = 0;
        end
      end
    end
  endtask

  task automatic check_regs();
    for (int u = 0; u < NU; u++) begin
      check($sformatf("out_valid[u%0d]", u), 64'(ov[u]), 64'(m_ov[u]));
      check($sformatf("out_data[u%0d]", u),  64'(od[u]), 64'(m_od[u]));
      check($sformatf("out_sel[u%0d]", u),   64'(os[u]), 64'(m_os[u]));
    end
  endtask

  // Inputs are set just after a rising edge; ready is checked mid-cycle,
  // registers 1 time unit after the next rising edge.
  task automatic cycle();
    #1;
    check_ready();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) in_data[i*XLEN +: XLEN] = $urandom;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  logic [XLEN-1:0] held_data;
  logic [1:0]      held_sel;
  int              seq3 [5] = '{0, 1, 2, 3, 0};
  int              seq5 [3] = '{0, 2, 0};

  initial begin
    reset_n = 1'b1; in_valid = '0; out_ready = 1'b1; in_data = '0;
    for (int u = 0; u < NU; u++) begin
      m_ov[u] = 0; m_od[u] = '0; m_os[u] = 0; m_rr[u] = 0;
    end
    @(posedge clk); #1;

    // Reset held two cycles with every channel requesting.
    reset_n = 1'b0; in_valid = '1; set_data();
    repeat (2) cycle();
    check("rst_out_valid", 64'(ov[0]), 64'd0);
    check("rst_out_data",  64'(od[1]), 64'd0);
    #1; check("rst_in_ready", 64'(rdy[1]), 64'd0);
    reset_n = 1'b1;
    cycle();
    check("first_sel_fp", 64'(os[0]), 64'd0);
    check("first_sel_rr", 64'(os[1]), 64'd0);

    // Fixed priority: ch1 wins over ch3 every cycle.
    do_reset();
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      set_data(); cycle();
      check("fp_sel_ch1", 64'(os[0]), 64'd1);
    end

    // Round-robin with all channels requesting.
    do_reset();
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      set_data(); cycle();
      check("rr_seq_sel", 64'(os[1]), 64'(seq3[k]));
      check("rr_seq_valid", 64'(ov[1]), 64'd1);
    end

    // Backpressure: register holds, ready low, then reloads with no bubble.
    held_data = od[0]; held_sel = os[0];
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_data(); cycle();
      check("bp_data_hold", 64'(od[0]), 64'(held_data));
      check("bp_sel_hold",  64'(os[0]), 64'(held_sel));
      check("bp_ready_low", 64'(rdy[0]), 64'd0);
    end
    out_ready = 1'b1; set_data();
    cycle();
    check("bp_release_valid", 64'(ov[0]), 64'd1);
    check("bp_release_data",  64'(od[0]), 64'(in_data[XLEN-1:0]));

    // Round-robin wrap with gaps: grant ch2 moves the pointer to 3.
    do_reset();
    in_valid = 4'b0100; set_data(); cycle();
    in_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      set_data(); cycle();
      check("rr_gap_sel", 64'(os[1]), 64'(seq5[k]));
      check("rr3_gap_sel", 64'(os[2]), 64'(seq5[k]));
    end

    // Reset while a beat is stalled: beat dropped, pointer back to 0.
    in_valid = 4'b1111; out_ready = 1'b0; set_data(); cycle();
    reset_n = 1'b0; cycle();
    check("midrst_valid", 64'(ov[1]), 64'd0);
    reset_n = 1'b1; out_ready = 1'b1; in_valid = 4'b1111; set_data(); cycle();
    check("midrst_rr_ptr0", 64'(os[1]), 64'd0);

    // Randomized traffic, backpressure and occasional resets.
    for (int k = 0; k < 600; k++) begin
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      reset_n   = ($urandom_range(0, 99) >= 2);
      set_data();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
